// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//   Parallel-in/serial-out feeder for the bit-serial sequence detectors.
//   WIDTH-bit words arrive over a valid/ready handshake. The block emits one bit
//   per clock on bit_out, and a one-word holding register lets back-to-back
//   words stream with no bubble between them.
//
// Handshake: a word transfers at a posedge where din_valid && din_ready. The
//   producer keeps din_valid high and din stable until that transfer happens.
//   din_ready is combinational (!reset && !buf_full), so it never depends on
//   din_valid.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high reset
//   din        in   WIDTH  parallel word to serialize
//   din_valid  in   1      din holds a valid word
//   din_ready  out  1      block can accept a word this cycle
//   bit_out    out  1      serial bit stream (0 while idle)
//   bit_valid  out  1      bit_out carries a word bit this cycle
//   word_done  out  1      bit_out is the last bit of the current word
//   busy       out  1      shifter or holding register holds data
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_reg;
  logic             buf_full;

  logic             xfer;
  logic             last;
  logic             head;
  logic [WIDTH-1:0] shreg_shifted;

  assign din_ready = !reset && !buf_full;
  assign xfer      = din_valid && din_ready;
  assign last      = (state == SHIFT) && (cnt == LAST);

  // The head bit is always the one on the wire; shifting moves the next bit
  // toward the head and backfills with zero.
  assign head          = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer) state_next = SHIFT;
      end
      SHIFT: begin
        // A word ends: stay in SHIFT when another word is ready (buffered or
        // bypassed straight from din), otherwise drop back to IDLE.
        if (last && !buf_full && !xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      shreg    <= '0;
      hold_reg <= '0;
      buf_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg <= din;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (!last) begin
            shreg <= shreg_shifted;
            cnt   <= cnt + 1'b1;
            if (xfer) begin
              hold_reg <= din;
              buf_full <= 1'b1;
            end
          end else begin
            cnt <= '0;
            if (buf_full) begin
              // din_ready is low here, so no transfer competes with the reload.
              shreg    <= hold_reg;
              buf_full <= 1'b0;
            end else if (xfer) begin
              // Empty buffer on the last bit: load the new word directly.
              shreg <= din;
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bit_valid = (state == SHIFT);
  assign bit_out   = bit_valid && head;
  assign word_done = last;
  assign busy      = (state == SHIFT) || buf_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//   Directed bench for seq_bit_serializer. Two instances share the stimulus:
//   dut_msb (MSB_FIRST=1) and dut_lsb (MSB_FIRST=0); sel picks which one is
//   driven and observed. A negedge monitor pops expected bits from exp_q,
//   checks word_done against the bit position within each word, flags idle
//   output levels, and counts bubbles while bits are still expected.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  // stimulus
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       sel = 1'b0;   // 0: dut_msb, 1: dut_lsb

  logic       rdy_m, bit_m, val_m, done_m, busy_m;
  logic       rdy_l, bit_l, val_l, done_l, busy_l;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid && !sel),
    .din_ready(rdy_m), .bit_out(bit_m), .bit_valid(val_m),
    .word_done(done_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid && sel),
    .din_ready(rdy_l), .bit_out(bit_l), .bit_valid(val_l),
    .word_done(done_l), .busy(busy_l)
  );

  logic rdy, m_bit, m_valid, m_done, m_busy;
  assign rdy     = sel ? rdy_l  : rdy_m;
  assign m_bit   = sel ? bit_l  : bit_m;
  assign m_valid = sel ? val_l  : val_m;
  assign m_done  = sel ? done_l : done_m;
  assign m_busy  = sel ? busy_l : busy_m;

  // scoreboard
  logic [0:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         gaps = 0;
  int         idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock, then settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    tick();
    check("rdy_in_reset", {31'd0, rdy}, 32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    idx = 0;
    gaps = 0;
    #1;
  endtask

  // Offer one word; returns the number of cycles it was held off.
  task automatic send(input logic [7:0] d, input bit msb, output int waited);
    int n;
    n = 0;
    din = d;
    din_valid = 1'b1;
    while (!rdy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd1, 32'd0);
    tick();                      // transfer edge
    din_valid = 1'b0;
    din = $urandom_range(0, 255); // din must be ignored once valid drops
    for (int i = 0; i < 8; i++) exp_q.push_back(msb ? d[7-i] : d[i]);
    waited = n;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, "_drain_timeout"}, 32'd1, 32'd0);
    tick();
    tick();
    check({tag, "_gaps"}, gaps, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, m_busy}, 32'd0);
    check({tag, "_idle_bit"}, {31'd0, m_bit}, 32'd0);
    check({tag, "_idle_rdy"}, {31'd0, rdy}, 32'd1);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          check("bit", {31'd0, m_bit}, {31'd0, exp_q.pop_front()});
          check("word_done", {31'd0, m_done}, (idx == 7) ? 32'd1 : 32'd0);
          idx = (idx + 1) % 8;
        end
      end else begin
        if (exp_q.size() != 0) gaps++;
        check("idle_out", {30'd0, m_bit, m_done}, 32'd0);
      end
    end
  end

  initial begin
    int w;

    // reset state
    do_reset();
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_bit", {31'd0, m_bit}, 32'd0);
    check("rst_done", {31'd0, m_done}, 32'd0);
    check("rst_busy", {31'd0, m_busy}, 32'd0);
    check("rst_rdy", {31'd0, rdy}, 32'd1);

    // 1: single word 8'hA0, MSB first -> 1,0,1,0,0,0,0,0
    send(8'hA0, 1'b1, w);
    check("t1_wait", w, 32'd0);
    check("t1_busy", {31'd0, m_busy}, 32'd1);
    check("t1_first_valid", {31'd0, m_valid}, 32'd1);
    check("t1_first_bit", {31'd0, m_bit}, 32'd1);
    drain("t1");

    // 2: back-to-back A5 then 5A, 16 contiguous bits
    send(8'hA5, 1'b1, w);
    send(8'h5A, 1'b1, w);
    check("t2_rdy_buf_full", {31'd0, rdy}, 32'd0);
    repeat (6) tick();
    check("t2_rdy_last_bit", {31'd0, rdy}, 32'd0);
    check("t2_done_last_bit", {31'd0, m_done}, 32'd1);
    tick();
    check("t2_rdy_after_load", {31'd0, rdy}, 32'd1);
    check("t2_busy_second", {31'd0, m_busy}, 32'd1);
    drain("t2");

    // 4: third word stalls while the buffer is full
    send(8'hA5, 1'b1, w);
    send(8'h5A, 1'b1, w);
    send(8'h3C, 1'b1, w);
    check("t4_stall_cycles", w, 32'd7);
    drain("t4");

    // 5: reset during bit 3 of 8'hFF with 8'h0F buffered
    send(8'hFF, 1'b1, w);
    send(8'h0F, 1'b1, w);
    tick();
    tick();
    check("t5_bit3_valid", {31'd0, m_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    idx = 0;
    #1;
    check("t5_valid", {31'd0, m_valid}, 32'd0);
    check("t5_bit", {31'd0, m_bit}, 32'd0);
    check("t5_busy", {31'd0, m_busy}, 32'd0);
    check("t5_rdy", {31'd0, rdy}, 32'd1);
    repeat (12) tick();  // monitor flags any leftover bit
    check("t5_quiet_busy", {31'd0, m_busy}, 32'd0);

    // 6: idle 20 cycles after reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check("t6_idle", {29'd0, m_bit, m_valid, m_busy}, 32'd0);
      tick();
    end

    // 3: LSB first, 8'h05 -> 1,0,1,0,0,0,0,0
    sel = 1'b1;
    do_reset();
    send(8'h05, 1'b0, w);
    check("t3_first_bit", {31'd0, m_bit}, 32'd1);
    drain("t3");

    // LSB first back-to-back 8'h81, 8'h0E
    send(8'h81, 1'b0, w);
    send(8'h0E, 1'b0, w);
    drain("t3b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
